// File: rtl/zigzag_pkg.sv
// Shared state encoding and default widths for the zigzag bit-plane address generator.
// Purely declarative; no latency or flow control of its own.
package zigzag_pkg;

   localparam int BWADDR_DEF = 21;
   localparam int BPREC_DEF  = 4;
   localparam int BITER_DEF  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/zigzag_walk.sv
// Diagonal walker over a pw x pd plane grid: current (offw,offd), diagonal-end and walk-end flags.
// Advances one pair per adv pulse, holds otherwise; the owner decides when to advance.
module zigzag_walk #(
   parameter int BPREC = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             init,
   input  logic             adv,
   input  logic [BPREC-1:0] pw,
   input  logic [BPREC-1:0] pd,
   output logic [BPREC-1:0] offw,
   output logic [BPREC-1:0] offd,
   output logic             sh,
   output logic             wend,
   output logic             nxt_wend
);

   localparam int BS = BPREC + 1;

   logic [BS-1:0]    k;
   logic [BS-1:0]    pw1;
   logic [BS-1:0]    pd1;
   logic [BS-1:0]    offw_x;
   logic [BS-1:0]    offd_x;
   logic [BS-1:0]    k_inc;
   logic [BS-1:0]    nxt_k;
   logic [BS-1:0]    nxt_offd;
   logic [BPREC-1:0] nxt_offw;

   // Extra bit keeps pw+pd-2 representable at full precision.
   assign pw1    = {1'b0, pw} - BS'(1);
   assign pd1    = {1'b0, pd} - BS'(1);
   assign offw_x = {1'b0, offw};
   assign offd_x = k - offw_x;
   assign k_inc  = k + BS'(1);

   assign sh   = (offw == '0) || (offd_x == pd1);
   assign wend = (offw_x == pw1) && (offd_x == pd1);

   always_comb begin
      nxt_k    = k;
      nxt_offw = offw;
      if (wend) begin
         nxt_k    = '0;
         nxt_offw = '0;
      end else if (sh) begin
         nxt_k    = k_inc;
         nxt_offw = (k_inc > pw1) ? pw1[BPREC-1:0] : k_inc[BPREC-1:0];
      end else begin
         nxt_offw = offw - BPREC'(1);
      end
   end

   assign nxt_offd = nxt_k - {1'b0, nxt_offw};
   assign nxt_wend = ({1'b0, nxt_offw} == pw1) && (nxt_offd == pd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k    <= '0;
         offw <= '0;
      end else if (init) begin
         k    <= '0;
         offw <= '0;
      end else if (adv) begin
         k    <= nxt_k;
         offw <= nxt_offw;
      end
   end

   assign offd = offd_x[BPREC-1:0];

endmodule

// File: rtl/zigzag_agu.sv
// Zigzag bit-plane AGU: first pair one cycle after start, then one pair per cycle with no bubbles.
// Valid/ready output register; everything holds while out_valid && !out_ready.
module zigzag_agu
   import zigzag_pkg::*;
#(
   parameter int BWADDR = BWADDR_DEF,
   parameter int BPREC  = BPREC_DEF,
   parameter int BITER  = BITER_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              start,
   output logic              start_rdy,
   input  logic [BPREC-1:0]  pw,
   input  logic [BPREC-1:0]  pd,
   input  logic [BWADDR-1:0] base_w,
   input  logic [BWADDR-1:0] base_d,
   input  logic [BWADDR-1:0] stride_w,
   input  logic [BWADDR-1:0] stride_d,
   input  logic [BWADDR-1:0] jump_w,
   input  logic [BWADDR-1:0] jump_d,
   input  logic [BITER-1:0]  niter,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [BPREC-1:0]  offw,
   output logic [BPREC-1:0]  offd,
   output logic [BWADDR-1:0] addr_w,
   output logic [BWADDR-1:0] addr_d,
   output logic              sh,
   output logic              msbw,
   output logic              msbd,
   output logic              last,
   output logic              cfg_err
);

   state_t            state;
   logic [BPREC-1:0]  pw_r, pd_r;
   logic [BWADDR-1:0] stride_w_r, stride_d_r, jump_w_r, jump_d_r;
   logic [BWADDR-1:0] ibase_w, ibase_d;
   logic [BITER-1:0]  nm1, iter;
   logic [BITER:0]    iter_inc;
   logic              accept, legal, xfer, walk_adv, single;
   logic              wend, nxt_wend, sh_raw, final_it, nxt_final, load_last;

   assign accept    = (state == IDLE) && start && !clr;
   assign legal     = (pw != '0) && (pd != '0);
   assign xfer      = out_valid && out_ready;
   assign walk_adv  = (state == RUN) && xfer && !clr;
   assign single    = (pw == BPREC'(1)) && (pd == BPREC'(1)) && (niter <= BITER'(1));
   assign final_it  = (iter == nm1);
   assign iter_inc  = {1'b0, iter} + (BITER+1)'(1);
   // The pair about to be loaded is last if it closes the walk of the final iteration.
   assign nxt_final = wend ? (iter_inc == {1'b0, nm1}) : final_it;
   assign load_last = nxt_wend && nxt_final;

   zigzag_walk #(.BPREC(BPREC)) u_walk (
      .clk      (clk),
      .rst_n    (rst_n),
      .init     (accept && legal),
      .adv      (walk_adv),
      .pw       (pw_r),
      .pd       (pd_r),
      .offw     (offw),
      .offd     (offd),
      .sh       (sh_raw),
      .wend     (wend),
      .nxt_wend (nxt_wend)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         out_valid  <= 1'b0;
         cfg_err    <= 1'b0;
         pw_r       <= '0;
         pd_r       <= '0;
         stride_w_r <= '0;
         stride_d_r <= '0;
         jump_w_r   <= '0;
         jump_d_r   <= '0;
         ibase_w    <= '0;
         ibase_d    <= '0;
         nm1        <= '0;
         iter       <= '0;
      end else begin
         cfg_err <= accept && !legal;
         if (clr) begin
            state     <= IDLE;
            out_valid <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start && legal) begin
                     pw_r       <= pw;
                     pd_r       <= pd;
                     stride_w_r <= stride_w;
                     stride_d_r <= stride_d;
                     jump_w_r   <= jump_w;
                     jump_d_r   <= jump_d;
                     ibase_w    <= base_w;
                     ibase_d    <= base_d;
                     nm1        <= (niter == '0) ? '0 : niter - BITER'(1);
                     iter       <= '0;
                     out_valid  <= 1'b1;
                     state      <= single ? DRAIN : RUN;
                  end
               end
               RUN: begin
                  if (xfer) begin
                     if (wend) begin
                        iter    <= iter_inc[BITER-1:0];
                        ibase_w <= ibase_w + jump_w_r;
                        ibase_d <= ibase_d + jump_d_r;
                     end
                     if (load_last)
                        state <= DRAIN;
                  end
               end
               DRAIN: begin
                  if (xfer) begin
                     out_valid <= 1'b0;
                     state     <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign start_rdy = (state == IDLE);
   assign addr_w    = ibase_w + stride_w_r * {{(BWADDR-BPREC){1'b0}}, offw};
   assign addr_d    = ibase_d + stride_d_r * {{(BWADDR-BPREC){1'b0}}, offd};
   assign sh        = out_valid && sh_raw;
   assign msbw      = out_valid && (offw == pw_r - BPREC'(1));
   assign msbd      = out_valid && (offd == pd_r - BPREC'(1));
   assign last      = out_valid && wend && final_it;

endmodule

// File: tb/tb_zigzag_agu.sv
// Bench for zigzag_agu: directed and random runs checked against a plain-arithmetic zigzag model.
module tb_zigzag_agu;

   localparam int BW = 21;
   localparam int BP = 4;
   localparam int BI = 8;

   typedef logic [63:0] vec_t;

   logic          clk = 1'b0;
   logic          rst_n, clr, start, out_ready;
   logic [BP-1:0] pw, pd;
   logic [BW-1:0] base_w, base_d, stride_w, stride_d, jump_w, jump_d;
   logic [BI-1:0] niter;
   logic          start_rdy, out_valid, sh, msbw, msbd, last, cfg_err;
   logic [BP-1:0] offw, offd;
   logic [BW-1:0] addr_w, addr_d;

   int   n_assert = 0;
   int   n_fail   = 0;
   vec_t exp_q[$];

   zigzag_agu #(.BWADDR(BW), .BPREC(BP), .BITER(BI)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .start(start), .start_rdy(start_rdy),
      .pw(pw), .pd(pd), .base_w(base_w), .base_d(base_d),
      .stride_w(stride_w), .stride_d(stride_d), .jump_w(jump_w), .jump_d(jump_d),
      .niter(niter), .out_valid(out_valid), .out_ready(out_ready),
      .offw(offw), .offd(offd), .addr_w(addr_w), .addr_d(addr_d),
      .sh(sh), .msbw(msbw), .msbd(msbd), .last(last), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, observed running expected done");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input vec_t obs, input vec_t expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic vec_t pack_out();
      return {10'd0, offw, offd, sh, msbw, msbd, last, addr_w, addr_d};
   endfunction

   task automatic build(input int p_w, input int p_d, input logic [BW-1:0] bw, input logic [BW-1:0] bd,
                        input logic [BW-1:0] sw, input logic [BW-1:0] sd, input logic [BW-1:0] jw,
                        input logic [BW-1:0] jd, input int n);
      int nn;
      logic [BW-1:0] aw, ad, jj, ow_v, od_v;
      exp_q.delete();
      nn = (n == 0) ? 1 : n;
      for (int j = 0; j < nn; j++) begin
         for (int k = 0; k <= p_w + p_d - 2; k++) begin
            int hi, lo;
            hi = (k < p_w - 1) ? k : p_w - 1;
            lo = (k - p_d + 1 > 0) ? k - p_d + 1 : 0;
            for (int ow = hi; ow >= lo; ow--) begin
               int od;
               od   = k - ow;
               jj   = BW'(j);
               ow_v = BW'(ow);
               od_v = BW'(od);
               aw   = bw + jj * jw + ow_v * sw;
               ad   = bd + jj * jd + od_v * sd;
               exp_q.push_back({10'd0, 4'(ow), 4'(od), (ow == lo), (ow == p_w - 1), (od == p_d - 1),
                                (j == nn - 1) && (k == p_w + p_d - 2), aw, ad});
            end
         end
      end
   endtask

   task automatic check_idle_zero(input string tag);
      chk({tag, "_start_rdy"}, start_rdy, 1);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_cfg_err"}, cfg_err, 0);
      chk({tag, "_outputs"}, pack_out(), 0);
   endtask

   // mode 0: ready held high, 1: ready toggling 0/1, 2: random ready
   task automatic run_case(input string name, input int p_w, input int p_d,
                           input logic [BW-1:0] bw, input logic [BW-1:0] bd,
                           input logic [BW-1:0] sw, input logic [BW-1:0] sd,
                           input logic [BW-1:0] jw, input logic [BW-1:0] jd,
                           input int n, input int mode, input bit busy_start);
      vec_t snap;
      bit   stalled;
      int   cyc, budget;
      build(p_w, p_d, bw, bd, sw, sd, jw, jd, n);
      budget = 8 * exp_q.size() + 20;
      chk({name, "_rdy_before"}, start_rdy, 1);
      pw = BP'(p_w); pd = BP'(p_d); base_w = bw; base_d = bd;
      stride_w = sw; stride_d = sd; jump_w = jw; jump_d = jd; niter = BI'(n);
      start = 1'b1;
      out_ready = (mode == 0);
      @(posedge clk); #1;
      start    = busy_start;
      pw       = busy_start ? '0 : BP'($urandom);
      pd       = BP'($urandom);
      base_w   = BW'($urandom); base_d = BW'($urandom);
      stride_w = BW'($urandom); stride_d = BW'($urandom);
      jump_w   = BW'($urandom); jump_d = BW'($urandom);
      niter    = BI'($urandom);
      chk({name, "_first_valid"}, out_valid, 1);
      stalled = 0;
      cyc = 0;
      while (exp_q.size() > 0 && cyc < budget) begin
         chk({name, "_valid"}, out_valid, 1);
         chk({name, "_busy_rdy"}, start_rdy, 0);
         chk({name, "_no_err"}, cfg_err, 0);
         if (stalled) chk({name, "_stall_hold"}, pack_out(), snap);
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 2 == 1);
            default: out_ready = ($urandom_range(0, 3) != 0);
         endcase
         if (out_valid && out_ready) begin
            chk({name, "_pair"}, pack_out(), exp_q.pop_front());
            stalled = 0;
         end else begin
            snap    = pack_out();
            stalled = out_valid;
         end
         if (exp_q.size() == 0) start = 1'b0;
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      chk({name, "_pairs_left"}, exp_q.size(), 0);
      chk({name, "_done_valid"}, out_valid, 0);
      chk({name, "_done_rdy"}, start_rdy, 1);
      out_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; clr = 1'b0; start = 1'b0; out_ready = 1'b0;
      pw = '0; pd = '0; base_w = '0; base_d = '0; stride_w = '0; stride_d = '0;
      jump_w = '0; jump_d = '0; niter = '0;

      #12;
      check_idle_zero("reset");
      #5 rst_n = 1'b1;
      @(posedge clk); #1;
      check_idle_zero("post_reset");

      run_case("seq_3x2", 3, 2, 21'h10, 21'h200, 21'h1, 21'h8, 21'h0, 21'h0, 1, 0, 0);
      run_case("addr_2x2", 2, 2, 21'h100, 21'h20, 21'h10, 21'h4, 21'h40, 21'h8, 2, 0, 0);
      run_case("stall_3x2", 3, 2, 21'h10, 21'h200, 21'h1, 21'h8, 21'h0, 21'h0, 1, 1, 0);

      // illegal configurations
      pw = 4'd3; pd = 4'd0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("pd0_err", cfg_err, 1);
      chk("pd0_rdy", start_rdy, 1);
      chk("pd0_valid", out_valid, 0);
      @(posedge clk); #1;
      chk("pd0_err_end", cfg_err, 0);
      chk("pd0_valid_end", out_valid, 0);
      pw = 4'd0; pd = 4'd2; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("pw0_err", cfg_err, 1);
      chk("pw0_valid", out_valid, 0);

      // clr beats a simultaneous legal start
      pw = 4'd2; pd = 4'd2; niter = 8'd1; start = 1'b1; clr = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; clr = 1'b0;
      chk("clr_start_valid", out_valid, 0);
      chk("clr_start_rdy", start_rdy, 1);
      chk("clr_start_err", cfg_err, 0);

      // clr on the third pair of a 4x4 run
      pw = 4'd4; pd = 4'd4; base_w = 21'h0; base_d = 21'h0; stride_w = 21'h1; stride_d = 21'h1;
      niter = 8'd1; start = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("clr_third_pair", {offw, offd}, 8'h01);
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      chk("clr_valid", out_valid, 0);
      chk("clr_rdy", start_rdy, 1);
      out_ready = 1'b0;
      run_case("after_clr", 4, 4, 21'h3000, 21'h77, 21'h100, 21'h3, 21'h5, 21'h9, 1, 2, 1);

      run_case("single", 1, 1, 21'h55, 21'h66, 21'h7, 21'h9, 21'h1000, 21'h2000, 3, 0, 0);
      run_case("wide_wrap", 15, 15, 21'h1FFFF0, 21'h1FFFFF, 21'h12345, 21'h1F0000, 21'h0, 21'h0, 1, 0, 0);

      // asynchronous reset in the middle of a run
      pw = 4'd5; pd = 4'd5; base_w = 21'h123; base_d = 21'h456; stride_w = 21'h11; stride_d = 21'h22;
      niter = 8'd2; start = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      #2 rst_n = 1'b0;
      #1;
      check_idle_zero("async_reset");
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      check_idle_zero("after_release");
      @(posedge clk); #1;
      chk("after_release_valid", out_valid, 0);
      out_ready = 1'b0;

      for (int r = 0; r < 6; r++) begin
         run_case($sformatf("rand%0d", r), $urandom_range(1, 6), $urandom_range(1, 6),
                  BW'($urandom), BW'($urandom), BW'($urandom), BW'($urandom),
                  BW'($urandom), BW'($urandom), $urandom_range(0, 3), 2, bit'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/zigzag_agu.md
ZIGZAG_AGU -- requirements
Module: zigzag_agu

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- BWADDR, 21, address bitwidth.
- BPREC, 4, precision-specifier bitwidth.
- BITER, 8, iteration-count bitwidth.

REQ-002 Ports, one per line: name, direction, width, meaning. One clock; reset is asynchronous and active-low.
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- clr  in  1  sync abort to IDLE.
- start  in  1  start request; accepted when start_rdy=1.
- start_rdy  out  1  high in IDLE.
- pw, pd  in  BPREC  weight/data precision in bit-planes.
- base_w, base_d  in  BWADDR  first-plane address.
- stride_w, stride_d  in  BWADDR  address distance between bit-planes.
- jump_w, jump_d  in  BWADDR  base increment between iterations.
- niter  in  BITER  iteration count; 0 means 1.
- out_valid  out  1  output pair valid.
- out_ready  in  1  consumer accepts.
- offw, offd  out  BPREC  plane indices.
- addr_w, addr_d  out  BWADDR  plane addresses.
- sh  out  1  last pair of its diagonal; accumulator shifts after it.
- msbw, msbd  out  1  offw==pw-1 / offd==pd-1 (signed-plane flags).
- last  out  1  final pair of the final iteration.
- cfg_err  out  1  one-cycle pulse on an illegal start.

Function
REQ-003 The block SHALL have states IDLE, RUN, DRAIN. Transitions: IDLE->RUN on an accepted legal start; RUN->DRAIN when the last pair is loaded into the output register; DRAIN->IDLE when that pair is accepted.
REQ-004 Start SHALL latch all configuration inputs. Configuration changes after acceptance SHALL have no effect.
REQ-005 A start with pw==0 or pd==0 SHALL be ignored, SHALL pulse cfg_err for one cycle, and the block SHALL remain in IDLE.
REQ-006 Each iteration SHALL emit all pw*pd pairs in order of diagonal k=0..pw+pd-2. Within diagonal k, offw SHALL run from min(k,pw-1) down to max(0,k-pd+1), with offd=k-offw.
REQ-007 sh SHALL be 1 exactly on the final pair of each diagonal, including the final diagonal.
REQ-008 Addresses SHALL be computed modulo 2^BWADDR: addr_w = base_w + j*jump_w + offw*stride_w, where j is the iteration index; addr_d likewise.
REQ-009 The first out_valid SHALL occur on the cycle after start is accepted.
REQ-010 With out_ready held at 1, one pair SHALL be emitted per cycle. There SHALL be no bubble between diagonals or between iterations.
REQ-011 While out_valid=1 and out_ready=0, all outputs SHALL hold stable.
REQ-012 last SHALL be asserted only with the final pair. start_rdy SHALL be 0 from acceptance until that pair is accepted.
REQ-013 A start asserted while not in IDLE SHALL be ignored and SHALL NOT raise cfg_err.
REQ-014 clr SHALL force IDLE and deassert out_valid on the next edge. If clr and start are asserted together, clr SHALL win and start SHALL be ignored.
REQ-015 pw=pd=1 SHALL produce a single pair per iteration with sh=1.
REQ-016 Internal diagonal sums SHALL be BPREC+1 bits wide, so pw+pd-2 SHALL never overflow.

Reset
REQ-017 rst_n low SHALL asynchronously force IDLE and clear all state. While in reset: start_rdy=1; out_valid, sh, last, msbw, msbd and cfg_err=0; offw, offd, addr_w and addr_d=0.
REQ-018 Reset deassertion mid-operation SHALL leave the block in IDLE, with no residual pair emitted.

Structure
REQ-019 Package zigzag_pkg SHALL hold the state enum and the default BWADDR, BPREC and BITER constants.
REQ-020 The diagonal walker (offw/offd/sh/end-of-walk generation) SHALL be a sub-module zigzag_walk. Address arithmetic, iteration counting and the handshake SHALL reside in zigzag_agu.

Verification
REQ-021 pw=3, pd=2, niter=1, out_ready=1 -> (offw,offd) sequence (0,0)sh, (1,0), (0,1)sh, (2,0), (1,1)sh, (2,1)sh+last; 6 consecutive valid cycles.
REQ-022 pw=2, pd=2, base_w=0x100, stride_w=0x10, jump_w=0x40, niter=2 -> addr_w sequence 100,110,100,110, then 140,150,140,150; last only on the 8th pair.
REQ-023 Same as REQ-021 with out_ready toggled 0/1 every cycle -> identical sequence; outputs stable during every stall cycle.
REQ-024 start with pd=0 -> cfg_err pulse for one cycle, start_rdy stays 1, no out_valid.
REQ-025 clr asserted at the 3rd pair of a pw=4, pd=4 run -> out_valid=0 and start_rdy=1 on the next cycle; a subsequent legal start runs cleanly.
REQ-026 rst_n pulled low mid-run, asynchronous to clk -> all outputs at reset values immediately, without waiting for a clock edge.
